// File: rtl/cnn_uart_tx.sv
// Result-byte transmitter: small FIFO feeding an 8N1 UART serialiser.
// tx_done pulses once at the end of every stop bit so cnn_core can hand over the next result.
module cnn_uart_tx #(
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done,
    output logic       bsy,
    output logic       fifo_full,
    output logic       ovf
);

    localparam int unsigned BAUD_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BAUD_W-1:0] r_baud_cnt;
    logic [BAUD_W-1:0] w_baud_nxt;
    logic [2:0]        r_bit_cnt;
    logic [2:0]        w_bit_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic              r_tx;
    logic              w_tx_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_bsy;
    logic              r_full;
    logic              r_ovf;

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              w_nonempty;
    logic              w_is_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_baud_end;
    logic [7:0]        w_head;

    assign w_nonempty  = (r_count != '0);
    assign w_is_full   = (r_count == CNT_W'(FIFO_DEPTH));
    // A full FIFO still accepts a byte when the FSM pops in the same cycle.
    assign w_push      = trmt && (!w_is_full || w_pop);
    assign w_drop      = trmt && w_is_full && !w_pop;
    assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_head      = r_mem[r_rd_ptr];
    assign w_baud_end  = (r_baud_cnt == BAUD_W'(BAUD_DIV - 1));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
            r_bsy      <= 1'b0;
            r_full     <= 1'b0;
            r_ovf      <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_cnt  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_done     <= w_done_nxt;
            r_bsy      <= (r_state != S_IDLE) || w_nonempty;
            r_full     <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
            r_ovf      <= r_ovf || w_drop;
            r_count    <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Frame sequencer; the line value is registered one cycle behind the state.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud_cnt;
        w_bit_nxt   = r_bit_cnt;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_done_nxt  = 1'b0;
        w_tx_nxt    = 1'b1;
        case (r_state)
            S_IDLE: begin
                if (w_nonempty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_baud_nxt  = '0;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                w_tx_nxt = 1'b0;
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end else begin
                    w_baud_nxt = r_baud_cnt + BAUD_W'(1);
                end
            end
            S_DATA: begin
                w_tx_nxt = r_shift[0];
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit_cnt + 3'd1;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    w_done_nxt = 1'b1;
                    w_baud_nxt = '0;
                    if (w_nonempty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_baud_nxt = r_baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign TX        = r_tx;
    assign tx_done   = r_done;
    assign bsy       = r_bsy;
    assign fifo_full = r_full;
    assign ovf       = r_ovf;

endmodule
